plab5_mcore_proc_req_acc: RTL and testbench

//  Processor-side request access control. Sits between a core's memory

---
 rtl/plab5_mcore_proc_req_acc.sv | 119 +++++++++++
 tb/tb_plab5_mcore_proc_req_acc.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/plab5_mcore_proc_req_acc.sv
// Processor-side request access control: stamps core security level,
// forwards permitted requests via a 2-entry queue, answers denied ones locally.
module plab5_mcore_proc_req_acc #(
    parameter int p_opaque_nbits = 8,
    parameter int p_addr_nbits   = 32,
    parameter int p_data_nbits   = 32,
    parameter logic [p_addr_nbits-1:0] p_sec_base = 32'h8000_0000,
    parameter int p_cnt_nbits    = 8,
    localparam int LenNb  = $clog2(p_data_nbits/8),
    localparam int ReqNb  = 3 + p_opaque_nbits + p_addr_nbits + LenNb + p_data_nbits,
    localparam int RespNb = 3 + p_opaque_nbits + LenNb + p_data_nbits
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   proc_sec_level,
    input  logic                   proc_req_val,
    output logic                   proc_req_rdy,
    input  logic [ReqNb-1:0]       proc_req_msg,
    output logic                   net_req_val,
    input  logic                   net_req_rdy,
    output logic [ReqNb-1:0]       net_req_msg,
    output logic                   req_sec_level,
    output logic                   deny_resp_val,
    input  logic                   deny_resp_rdy,
    output logic [RespNb-1:0]      deny_resp_msg,
    output logic                   viol_flag,
    output logic [p_cnt_nbits-1:0] viol_count
);

    typedef enum logic {EMPTY, FULL} deny_st_e;

    logic [ReqNb:0]          ent0_q, ent0_d, ent1_q, ent1_d;
    logic [1:0]              cnt_q, cnt_d;
    deny_st_e                st_q, st_d;
    logic [RespNb-1:0]       dmsg_q, dmsg_d;
    logic                    flag_q, flag_d;
    logic [p_cnt_nbits-1:0]  vcnt_q, vcnt_d;

    logic [p_addr_nbits-1:0]   addr;
    logic [p_opaque_nbits-1:0] opq;
    logic [2:0]                rtype;
    logic                      denied, acc, enq, dacc, deq;

    // Message layout, MSB first: type, opaque, addr, len, data
    assign rtype = proc_req_msg[ReqNb-1 -: 3];
    assign opq   = proc_req_msg[LenNb+p_data_nbits+p_addr_nbits +: p_opaque_nbits];
    assign addr  = proc_req_msg[LenNb+p_data_nbits +: p_addr_nbits];

    assign denied = !proc_sec_level && (addr >= p_sec_base);

    assign proc_req_rdy = (cnt_q < 2'd2) && (st_q == EMPTY);
    assign acc  = proc_req_val && proc_req_rdy;
    assign enq  = acc && !denied;
    assign dacc = acc && denied;
    assign deq  = net_req_val && net_req_rdy;

    assign net_req_val   = (cnt_q != 2'd0);
    assign net_req_msg   = ent0_q[ReqNb-1:0];
    assign req_sec_level = ent0_q[ReqNb];
    assign deny_resp_val = (st_q == FULL);
    assign deny_resp_msg = dmsg_q;
    assign viol_flag     = flag_q;
    assign viol_count    = vcnt_q;

    // Shift queue: entry 0 is always the head
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        cnt_d  = cnt_q;
        if (deq) begin
            ent0_d = ent1_q;
            cnt_d  = cnt_q - 2'd1;
        end
        if (enq) begin
            if (cnt_d == 2'd0) ent0_d = {proc_sec_level, proc_req_msg};
            else               ent1_d = {proc_sec_level, proc_req_msg};
            cnt_d = cnt_d + 2'd1;
        end
    end

    always_comb begin
        st_d   = st_q;
        dmsg_d = dmsg_q;
        flag_d = flag_q;
        vcnt_d = vcnt_q;
        unique case (st_q)
            EMPTY: if (dacc) begin
                st_d   = FULL;
                dmsg_d = {rtype, opq, {LenNb{1'b0}}, {p_data_nbits{1'b0}}};
            end
            FULL: if (deny_resp_rdy) st_d = EMPTY;
        endcase
        if (dacc) begin
            flag_d = 1'b1;
            if (vcnt_q != '1) vcnt_d = vcnt_q + p_cnt_nbits'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= 2'd0;
            st_q   <= EMPTY;
            dmsg_q <= '0;
            flag_q <= 1'b0;
            vcnt_q <= '0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            cnt_q  <= cnt_d;
            st_q   <= st_d;
            dmsg_q <= dmsg_d;
            flag_q <= flag_d;
            vcnt_q <= vcnt_d;
        end
    end

endmodule

// File: tb/tb_plab5_mcore_proc_req_acc.sv
// Bench for plab5_mcore_proc_req_acc: scoreboard queues for forwarded
// requests and local error responses, plus a violation-counter model.
module tb_plab5_mcore_proc_req_acc;

    localparam int RQ = 77;
    localparam int RS = 45;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          proc_sec_level;
    logic          proc_req_val;
    logic          proc_req_rdy;
    logic [RQ-1:0] proc_req_msg;
    logic          net_req_val;
    logic          net_req_rdy;
    logic [RQ-1:0] net_req_msg;
    logic          req_sec_level;
    logic          deny_resp_val;
    logic          deny_resp_rdy;
    logic [RS-1:0] deny_resp_msg;
    logic          viol_flag;
    logic [7:0]    viol_count;

    plab5_mcore_proc_req_acc dut (
        .clk(clk), .reset_n(reset_n),
        .proc_sec_level(proc_sec_level),
        .proc_req_val(proc_req_val), .proc_req_rdy(proc_req_rdy),
        .proc_req_msg(proc_req_msg),
        .net_req_val(net_req_val), .net_req_rdy(net_req_rdy),
        .net_req_msg(net_req_msg), .req_sec_level(req_sec_level),
        .deny_resp_val(deny_resp_val), .deny_resp_rdy(deny_resp_rdy),
        .deny_resp_msg(deny_resp_msg),
        .viol_flag(viol_flag), .viol_count(viol_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int deq_cnt = 0;
    bit mon_en = 1'b0;
    logic          m_flag = 1'b0;
    logic [7:0]    m_cnt = 8'd0;
    logic [RQ:0]   nq[$];
    logic [RS-1:0] dq[$];

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [RQ-1:0] mk(input logic [2:0] t,
                                         input logic [7:0] o,
                                         input logic [31:0] a,
                                         input logic [31:0] d);
        return {t, o, a, 2'b00, d};
    endfunction

    // Observe mid-cycle; inputs only change just after posedge
    always @(negedge clk) begin
        if (reset_n && mon_en) begin
            chk("rdy", 128'(proc_req_rdy),
                128'(nq.size() < 2 && dq.size() == 0));
            chk("nval", 128'(net_req_val), 128'(nq.size() != 0));
            chk("dval", 128'(deny_resp_val), 128'(dq.size() != 0));
            chk("vflag", 128'(viol_flag), 128'(m_flag));
            chk("vcnt", 128'(viol_count), 128'(m_cnt));
            if (net_req_val && nq.size() != 0) begin
                chk("nmsg", 128'(net_req_msg), 128'(nq[0][RQ-1:0]));
                chk("nlvl", 128'(req_sec_level), 128'(nq[0][RQ]));
            end
            if (deny_resp_val && dq.size() != 0)
                chk("dmsg", 128'(deny_resp_msg), 128'(dq[0]));
            if (net_req_val && net_req_rdy && nq.size() != 0) begin
                void'(nq.pop_front());
                deq_cnt++;
            end
            if (deny_resp_val && deny_resp_rdy && dq.size() != 0)
                void'(dq.pop_front());
            if (proc_req_val && proc_req_rdy) begin
                if (!proc_sec_level && proc_req_msg[65:34] >= 32'h8000_0000) begin
                    dq.push_back({proc_req_msg[76:74], proc_req_msg[73:66],
                                  2'b00, 32'h0});
                    m_flag = 1'b1;
                    if (m_cnt != 8'hFF) m_cnt++;
                end else begin
                    nq.push_back({proc_sec_level, proc_req_msg});
                end
            end
        end
    end

    // Called just after a posedge; returns just after the accepting edge
    task automatic send(input logic lvl, input logic [RQ-1:0] m);
        int t = 0;
        proc_sec_level = lvl;
        proc_req_msg   = m;
        proc_req_val   = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!proc_req_rdy && t < 100);
        if (!proc_req_rdy) chk("send_timeout", 128'(0), 128'(1));
        @(posedge clk); #1;
        proc_req_val = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        net_req_rdy   = 1'b1;
        deny_resp_rdy = 1'b1;
        while ((nq.size() != 0 || dq.size() != 0) && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain", 128'(nq.size() == 0 && dq.size() == 0), 128'(1));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        proc_req_val   = 1'b0;
        proc_sec_level = 1'b0;
        proc_req_msg   = '0;
        net_req_rdy    = 1'b0;
        deny_resp_rdy  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_nval", 128'(net_req_val), 128'(0));
        chk("rst_dval", 128'(deny_resp_val), 128'(0));
        chk("rst_flag", 128'(viol_flag), 128'(0));
        chk("rst_cnt", 128'(viol_count), 128'(0));
        chk("rst_lvl", 128'(req_sec_level), 128'(0));
        reset_n = 1'b1;
        mon_en  = 1'b1;
        @(posedge clk); #1;

        // low core, low region read
        net_req_rdy = 1'b1;
        send(1'b0, mk(3'd0, 8'h11, 32'h0000_1000, 32'h0));
        chk("t1_nval", 128'(net_req_val), 128'(1));
        chk("t1_lvl", 128'(req_sec_level), 128'(0));
        drain();
        chk("t1_cnt", 128'(viol_count), 128'(0));

        // high core write held by backpressure, queue fills
        net_req_rdy = 1'b0;
        send(1'b1, mk(3'd1, 8'h22, 32'h8000_0040, 32'hDEAD_BEEF));
        repeat (3) @(posedge clk);
        #1;
        send(1'b0, mk(3'd0, 8'h23, 32'h0000_2000, 32'h0));
        @(negedge clk);
        chk("t2_full_rdy", 128'(proc_req_rdy), 128'(0));
        chk("t2_head_lvl", 128'(req_sec_level), 128'(1));
        @(posedge clk); #1;
        drain();

        // low core to secure region is denied
        net_req_rdy   = 1'b1;
        deny_resp_rdy = 1'b0;
        send(1'b0, mk(3'd0, 8'h5A, 32'h8000_0000, 32'h1234_5678));
        repeat (3) begin
            @(negedge clk);
            chk("t3_rdy", 128'(proc_req_rdy), 128'(0));
            chk("t3_nval", 128'(net_req_val), 128'(0));
        end
        chk("t3_opq", 128'(deny_resp_msg[41:34]), 128'(8'h5A));
        chk("t3_data", 128'(deny_resp_msg[31:0]), 128'(0));
        chk("t3_flag", 128'(viol_flag), 128'(1));
        chk("t3_cnt", 128'(viol_count), 128'(1));
        @(posedge clk); #1;
        drain();

        // counter saturation
        deny_resp_rdy = 1'b1;
        for (int i = 0; i < 259; i++)
            send(1'b0, mk(3'd0, 8'(i), 32'(32'h8000_0000 + i * 4), 32'(i)));
        drain();
        chk("t4_cnt", 128'(viol_count), 128'(8'hFF));
        chk("t4_flag", 128'(viol_flag), 128'(1));

        // simultaneous enq+deq at count 1
        net_req_rdy = 1'b0;
        send(1'b0, mk(3'd0, 8'h70, 32'h0000_0100, 32'h0));
        base = deq_cnt;
        net_req_rdy    = 1'b1;
        proc_req_val   = 1'b1;
        proc_sec_level = 1'b1;
        for (int i = 0; i < 10; i++) begin
            proc_req_msg = mk(3'd1, 8'(8'h80 + i), 32'(32'h200 + i * 4), 32'(i));
            @(posedge clk); #1;
        end
        proc_req_val = 1'b0;
        chk("t5_thru", 128'(deq_cnt - base), 128'(10));
        drain();

        // async reset with a queued request and a pending error response
        net_req_rdy   = 1'b0;
        deny_resp_rdy = 1'b0;
        send(1'b0, mk(3'd0, 8'h61, 32'h0000_0300, 32'h0));
        send(1'b0, mk(3'd0, 8'h62, 32'h8000_0100, 32'h0));
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_nval", 128'(net_req_val), 128'(0));
        chk("t6_dval", 128'(deny_resp_val), 128'(0));
        chk("t6_flag", 128'(viol_flag), 128'(0));
        chk("t6_cnt", 128'(viol_count), 128'(0));
        nq.delete();
        dq.delete();
        m_flag = 1'b0;
        m_cnt  = 8'd0;
        @(posedge clk); #1;
        reset_n     = 1'b1;
        net_req_rdy = 1'b1;
        @(posedge clk); #1;
        send(1'b0, mk(3'd0, 8'h63, 32'h0000_0400, 32'hA5A5_0000));
        chk("t6_post_nval", 128'(net_req_val), 128'(1));
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
